// File: rtl/muldiv_pkg.sv
// Shared encodings for the M-extension multiply/divide sequencer:
// funct codes, FSM state encoding and default widths.
package muldiv_pkg;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_CNT_W = 6;

  localparam logic [2:0] F_MUL    = 3'd0;
  localparam logic [2:0] F_MULH   = 3'd1;
  localparam logic [2:0] F_MULHSU = 3'd2;
  localparam logic [2:0] F_MULHU  = 3'd3;
  localparam logic [2:0] F_DIV    = 3'd4;
  localparam logic [2:0] F_DIVU   = 3'd5;
  localparam logic [2:0] F_REM    = 3'd6;
  localparam logic [2:0] F_REMU   = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CALC,
    ST_FIX,
    ST_DONE
  } state_t;

endpackage

// File: rtl/muldiv_datapath.sv
// Iterative shift-add multiplier / restoring divider on operand magnitudes.
// acc holds {hi, lo} of the product, or {remainder, quotient} while dividing.
module muldiv_datapath #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic               step,
  input  logic               fix,
  input  logic               load_div,
  input  logic               load_hi,
  input  logic               load_neg,
  input  logic [2*WIDTH-1:0] load_acc,
  input  logic [WIDTH-1:0]   load_opnd,
  output logic               cnt_one,
  output logic [WIDTH-1:0]   result
);

  logic [2*WIDTH-1:0] acc_reg, acc_step, prod_fixed;
  logic [WIDTH-1:0]   opnd_reg, result_reg, rem_sub, half, half_fixed, fix_val;
  logic [WIDTH:0]     add_sum, rem_shift;
  logic [CNT_W-1:0]   cnt_reg;
  logic               div_reg, hi_reg, neg_reg, borrow;

  always_comb begin
    add_sum   = {1'b0, acc_reg[2*WIDTH-1:WIDTH]} + (acc_reg[0] ? {1'b0, opnd_reg} : '0);
    rem_shift = {acc_reg[2*WIDTH-1:WIDTH], acc_reg[WIDTH-1]};
    borrow    = rem_shift < {1'b0, opnd_reg};
    // No borrow means the true difference is below the divisor, so W bits suffice.
    rem_sub   = rem_shift[WIDTH-1:0] - opnd_reg;
    if (div_reg)
      acc_step = borrow ? {rem_shift[WIDTH-1:0], acc_reg[WIDTH-2:0], 1'b0}
                        : {rem_sub, acc_reg[WIDTH-2:0], 1'b1};
    else
      acc_step = {add_sum, acc_reg[WIDTH-1:1]};
  end

  always_comb begin
    prod_fixed = neg_reg ? -acc_reg : acc_reg;
    half       = hi_reg ? acc_reg[2*WIDTH-1:WIDTH] : acc_reg[WIDTH-1:0];
    half_fixed = neg_reg ? -half : half;
    if (div_reg)
      fix_val = half_fixed;
    else
      fix_val = hi_reg ? prod_fixed[2*WIDTH-1:WIDTH] : prod_fixed[WIDTH-1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_reg    <= '0;
      opnd_reg   <= '0;
      cnt_reg    <= '0;
      div_reg    <= 1'b0;
      hi_reg     <= 1'b0;
      neg_reg    <= 1'b0;
      result_reg <= '0;
    end else begin
      if (load) begin
        acc_reg  <= load_acc;
        opnd_reg <= load_opnd;
        cnt_reg  <= CNT_W'(WIDTH);
        div_reg  <= load_div;
        hi_reg   <= load_hi;
        neg_reg  <= load_neg;
      end else if (step) begin
        acc_reg <= acc_step;
        cnt_reg <= cnt_reg - CNT_W'(1);
      end
      if (fix)
        result_reg <= fix_val;
    end
  end

  assign cnt_one = (cnt_reg == CNT_W'(1));
  assign result  = result_reg;

endmodule

// File: rtl/muldiv_sequencer.sv
// M-extension multi-cycle controller: FSM, stall and special-case detection.
// Define MULDIV_EARLY_OUT_EN to send zero-operand ops straight to FIX.
module muldiv_sequencer
  import muldiv_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       funct,
  input  logic [WIDTH-1:0] rs1_data,
  input  logic [WIDTH-1:0] rs2_data,
  output logic             stall,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam logic [WIDTH-1:0] MIN_NEG  = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};

  state_t state_reg, state_next;

  logic               signed_a, signed_b, sel_hi, is_rem, is_div;
  logic               sa, sb, div_zero, overflow, early, special;
  logic               load, step, fix, cnt_one, load_neg;
  logic [WIDTH-1:0]   a_mag, b_mag, load_opnd;
  logic [2*WIDTH-1:0] load_acc;

  always_comb begin
    signed_a = 1'b0;
    signed_b = 1'b0;
    sel_hi   = 1'b0;
    is_rem   = 1'b0;
    case (funct)
      F_MUL:    ;
      F_MULH:   begin signed_a = 1'b1; signed_b = 1'b1; sel_hi = 1'b1; end
      F_MULHSU: begin signed_a = 1'b1; sel_hi = 1'b1; end
      F_MULHU:  sel_hi = 1'b1;
      F_DIV:    begin signed_a = 1'b1; signed_b = 1'b1; end
      F_DIVU:   ;
      F_REM:    begin signed_a = 1'b1; signed_b = 1'b1; sel_hi = 1'b1; is_rem = 1'b1; end
      F_REMU:   begin sel_hi = 1'b1; is_rem = 1'b1; end
      default:  ;
    endcase
  end

  assign is_div   = funct[2];
  assign sa       = signed_a & rs1_data[WIDTH-1];
  assign sb       = signed_b & rs2_data[WIDTH-1];
  assign a_mag    = sa ? -rs1_data : rs1_data;
  assign b_mag    = sb ? -rs2_data : rs2_data;
  assign div_zero = is_div & (rs2_data == '0);
  assign overflow = is_div & signed_a & (rs1_data == MIN_NEG) & (rs2_data == ALL_ONES);

`ifdef MULDIV_EARLY_OUT_EN
  assign early = (~is_div & ((rs1_data == '0) | (rs2_data == '0)))
               | (is_div & (rs1_data == '0) & (rs2_data != '0));
`else
  assign early = 1'b0;
`endif

  assign special = div_zero | overflow | early;

  // Special cases preload acc so the FIX stage's normal selection yields the answer.
  always_comb begin
    load_acc  = {{WIDTH{1'b0}}, is_div ? a_mag : b_mag};
    load_opnd = is_div ? b_mag : a_mag;
    load_neg  = is_rem ? sa : (sa ^ sb);
    if (div_zero) begin
      load_acc = {rs1_data, ALL_ONES};
      load_neg = 1'b0;
    end else if (overflow) begin
      load_acc = {{WIDTH{1'b0}}, MIN_NEG};
      load_neg = 1'b0;
    end else if (early) begin
      load_acc = '0;
      load_neg = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state_reg <= ST_IDLE;
    else
      state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    load       = 1'b0;
    step       = 1'b0;
    fix        = 1'b0;
    stall      = 1'b0;
    done       = 1'b0;
    case (state_reg)
      ST_IDLE: if (start) begin
        load       = 1'b1;
        stall      = 1'b1;
        state_next = special ? ST_FIX : ST_CALC;
      end
      ST_CALC: begin
        step  = 1'b1;
        stall = 1'b1;
        if (cnt_one)
          state_next = ST_FIX;
      end
      ST_FIX: begin
        fix        = 1'b1;
        stall      = 1'b1;
        state_next = ST_DONE;
      end
      ST_DONE: begin
        done       = 1'b1;
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign busy = (state_reg != ST_IDLE);

  muldiv_datapath #(
    .WIDTH(WIDTH),
    .CNT_W(CNT_W)
  ) u_datapath (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .step     (step),
    .fix      (fix),
    .load_div (is_div),
    .load_hi  (sel_hi),
    .load_neg (load_neg),
    .load_acc (load_acc),
    .load_opnd(load_opnd),
    .cnt_one  (cnt_one),
    .result   (result)
  );

endmodule
